// File: rtl/bip_exec_unit.sv
// Execute stage of the BIP accumulator processor: accumulator, add/sub ALU and synchronous data RAM.
// Optional `zero`/`neg` status flags are built when BIP_FLAGS_EN is defined.
module bip_exec_unit #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 11,
    parameter int RAM_DEPTH = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [ADDR_W-1:0] operand,
    input  logic              WrPC,
    input  logic [1:0]        SelA,
    input  logic              SelB,
    input  logic              WrAcc,
    input  logic              Op,
    input  logic              WrRam,
    input  logic              RdRam,
    output logic [DATA_W-1:0] acc,
    output logic              halted,
    output logic              retire
`ifdef BIP_FLAGS_EN
    ,
    output logic              zero,
    output logic              neg
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_RD = 2'd1,
        HALT    = 2'd2
    } stateT;

    stateT             stateReg;
    logic              readyReg;
    logic              haltedReg;
    logic              retireReg;
    logic [DATA_W-1:0] accReg;

    // Control captured on a RAM-read accept, consumed one edge later
    logic [1:0]        selAReg;
    logic              selBReg;
    logic              opReg;
    logic              wrAccReg;
    logic [ADDR_W-1:0] operandReg;

    logic [DATA_W-1:0] ram [RAM_DEPTH];
    logic [DATA_W-1:0] ramRdData;

    logic              accept;
    logic              inWait;
    logic [1:0]        exSelA;
    logic              exSelB;
    logic              exOp;
    logic              exWrAcc;
    logic [ADDR_W-1:0] exOperand;
    logic [DATA_W-1:0] immExt;
    logic [DATA_W-1:0] bVal;
    logic [DATA_W-1:0] aluRes;
    logic [DATA_W-1:0] accNext;
    logic              doAccWrite;

    assign instr_ready = readyReg & ~rst;
    assign accept      = instr_valid & instr_ready;
    assign acc         = accReg;
    assign halted      = haltedReg;
    assign retire      = retireReg;

    // One datapath serves both the single-cycle path (live inputs) and the load completion (latched)
    always_comb begin
        inWait    = (stateReg == WAIT_RD);
        exSelA    = inWait ? selAReg    : SelA;
        exSelB    = inWait ? selBReg    : SelB;
        exOp      = inWait ? opReg      : Op;
        exWrAcc   = inWait ? wrAccReg   : WrAcc;
        exOperand = inWait ? operandReg : operand;
        immExt    = {{(DATA_W-ADDR_W){exOperand[ADDR_W-1]}}, exOperand};
        bVal      = exSelB ? immExt : ramRdData;
        aluRes    = exOp ? (accReg - bVal) : (accReg + bVal);
        case (exSelA)
            2'b00:   accNext = ramRdData;
            2'b01:   accNext = immExt;
            2'b10:   accNext = aluRes;
            default: accNext = accReg;
        endcase
        doAccWrite = exWrAcc && (exSelA != 2'b11) &&
                     (inWait || (stateReg == RUN && accept && WrPC && !RdRam));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= RUN;
            readyReg   <= 1'b1;
            haltedReg  <= 1'b0;
            retireReg  <= 1'b0;
            selAReg    <= 2'b00;
            selBReg    <= 1'b0;
            opReg      <= 1'b0;
            wrAccReg   <= 1'b0;
            operandReg <= '0;
        end else begin
            retireReg <= 1'b0;
            case (stateReg)
                RUN: begin
                    if (accept) begin
                        if (!WrPC) begin
                            stateReg  <= HALT;
                            readyReg  <= 1'b0;
                            haltedReg <= 1'b1;
                            retireReg <= 1'b1;
                        end else if (RdRam) begin
                            stateReg   <= WAIT_RD;
                            readyReg   <= 1'b0;
                            selAReg    <= SelA;
                            selBReg    <= SelB;
                            opReg      <= Op;
                            wrAccReg   <= WrAcc;
                            operandReg <= operand;
                        end else begin
                            retireReg <= 1'b1;
                        end
                    end
                end
                WAIT_RD: begin
                    stateReg  <= RUN;
                    readyReg  <= 1'b1;
                    retireReg <= 1'b1;
                end
                default: begin
                    stateReg <= HALT;
                    readyReg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accReg <= '0;
`ifdef BIP_FLAGS_EN
            zero   <= 1'b0;
            neg    <= 1'b0;
`endif
        end else if (doAccWrite) begin
            accReg <= accNext;
`ifdef BIP_FLAGS_EN
            zero   <= (accNext == '0);
            neg    <= accNext[DATA_W-1];
`endif
        end
    end

    // RAM has no reset so it maps onto block RAM; store sees the pre-edge accumulator
    always_ff @(posedge clk) begin
        if (accept && WrPC && WrRam)
            ram[operand] <= accReg;
        if (accept && WrPC && RdRam)
            ramRdData <= ram[operand];
    end

endmodule

// File: tb/tb_bip_exec_unit.sv
// Directed self-checking bench for bip_exec_unit; flag checks compile in with BIP_FLAGS_EN.
module tb_bip_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [10:0] operand = '0;
    logic        WrPC = 1'b1;
    logic [1:0]  SelA = 2'b00;
    logic        SelB = 1'b0;
    logic        WrAcc = 1'b0;
    logic        Op = 1'b0;
    logic        WrRam = 1'b0;
    logic        RdRam = 1'b0;
    logic [15:0] acc;
    logic        halted;
    logic        retire;
`ifdef BIP_FLAGS_EN
    logic        zero;
    logic        neg;
`endif

    int checks = 0;
    int passed = 0;
    int retireCount = 0;
    int rc0;

    bip_exec_unit dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .operand(operand), .WrPC(WrPC), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc),
        .Op(Op), .WrRam(WrRam), .RdRam(RdRam), .acc(acc), .halted(halted), .retire(retire)
`ifdef BIP_FLAGS_EN
        , .zero(zero), .neg(neg)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (retire === 1'b1) retireCount++;

    // Drive one instruction, wait for its accept edge, then drop valid.
    task automatic issue(input logic [10:0] opnd, input logic wrPc, input logic [1:0] selA,
                         input logic selB, input logic wrAcc, input logic op,
                         input logic wrRam, input logic rdRam);
        @(negedge clk);
        operand = opnd; WrPC = wrPc; SelA = selA; SelB = selB;
        WrAcc = wrAcc; Op = op; WrRam = wrRam; RdRam = rdRam;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        $display("issue opnd=%03h WrPC=%0b SelA=%0b SelB=%0b WrAcc=%0b Op=%0b WrRam=%0b RdRam=%0b -> acc=%04h",
                 opnd, wrPc, selA, selB, wrAcc, op, wrRam, rdRam, acc);
    endtask

    task automatic ldi(input logic [10:0] imm);  issue(imm, 1, 2'b01, 0, 1, 0, 0, 0); endtask
    task automatic addi(input logic [10:0] imm); issue(imm, 1, 2'b10, 1, 1, 0, 0, 0); endtask
    task automatic subi(input logic [10:0] imm); issue(imm, 1, 2'b10, 1, 1, 1, 0, 0); endtask
    task automatic sto(input logic [10:0] a);    issue(a, 1, 2'b00, 0, 0, 0, 1, 0); endtask
    task automatic ld(input logic [10:0] a);
        issue(a, 1, 2'b00, 0, 1, 0, 0, 1);
        @(posedge clk); #1;
    endtask
    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (acc !== 16'h0000) $display("FAIL reset_acc got=%04h exp=0000", acc); else passed++;
        checks++; if (halted !== 1'b0) $display("FAIL reset_halted got=%0b exp=0", halted); else passed++;
        checks++; if (retire !== 1'b0) $display("FAIL reset_retire got=%0b exp=0", retire); else passed++;
        checks++; if (instr_ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", instr_ready); else passed++;
`ifdef BIP_FLAGS_EN
        checks++; if ({zero, neg} !== 2'b00) $display("FAIL reset_flags got=%0b%0b exp=00", zero, neg); else passed++;
`endif
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (instr_ready !== 1'b1) $display("FAIL ready_after_reset got=%0b exp=1", instr_ready); else passed++;
    endtask

    task automatic test_ldi();
        settle(); rc0 = retireCount;
        ldi(11'd5);
        checks++; if (acc !== 16'h0005) $display("FAIL ldi_acc got=%04h exp=0005", acc); else passed++;
        checks++; if (retire !== 1'b1) $display("FAIL ldi_retire got=%0b exp=1", retire); else passed++;
        checks++; if (instr_ready !== 1'b1) $display("FAIL ldi_ready got=%0b exp=1", instr_ready); else passed++;
        settle();
        checks++; if (retireCount - rc0 !== 1) $display("FAIL ldi_retire_count got=%0d exp=1", retireCount - rc0); else passed++;
    endtask

    task automatic test_store_load();
        settle(); rc0 = retireCount;
        ldi(11'd5); sto(11'd3); ldi(11'd0);
        checks++; if (acc !== 16'h0000) $display("FAIL sl_ldi0 got=%04h exp=0000", acc); else passed++;
        issue(11'd3, 1, 2'b00, 0, 1, 0, 0, 1);
        checks++; if (instr_ready !== 1'b0) $display("FAIL ld_ready_low got=%0b exp=0", instr_ready); else passed++;
        checks++; if (acc !== 16'h0000) $display("FAIL ld_acc_early got=%04h exp=0000", acc); else passed++;
        @(posedge clk); #1;
        checks++; if (acc !== 16'h0005) $display("FAIL ld_acc got=%04h exp=0005", acc); else passed++;
        checks++; if (instr_ready !== 1'b1) $display("FAIL ld_ready_back got=%0b exp=1", instr_ready); else passed++;
        checks++; if (retire !== 1'b1) $display("FAIL ld_retire got=%0b exp=1", retire); else passed++;
        settle();
        checks++; if (retireCount - rc0 !== 4) $display("FAIL sl_retire_count got=%0d exp=4", retireCount - rc0); else passed++;
    endtask

    task automatic test_back_to_back();
        ldi(11'h123);
        sto(11'd7);
        issue(11'd7, 1, 2'b10, 0, 1, 0, 0, 1);  // ADD 7 on the very next edge
        @(posedge clk); #1;
        checks++; if (acc !== 16'h0246) $display("FAIL b2b_add got=%04h exp=0246", acc); else passed++;
    endtask

    task automatic test_wrap();
        ldi(11'h7FF);
        checks++; if (acc !== 16'hFFFF) $display("FAIL signext got=%04h exp=FFFF", acc); else passed++;
`ifdef BIP_FLAGS_EN
        checks++; if ({zero, neg} !== 2'b01) $display("FAIL flags_ffff got=%0b%0b exp=01", zero, neg); else passed++;
`endif
        addi(11'd1);
        checks++; if (acc !== 16'h0000) $display("FAIL wrap_add got=%04h exp=0000", acc); else passed++;
`ifdef BIP_FLAGS_EN
        checks++; if ({zero, neg} !== 2'b10) $display("FAIL flags_zero got=%0b%0b exp=10", zero, neg); else passed++;
        sto(11'd9);
        checks++; if ({zero, neg} !== 2'b10) $display("FAIL flags_sto got=%0b%0b exp=10", zero, neg); else passed++;
`endif
    endtask

    task automatic test_sub();
        ldi(11'd3); subi(11'd5);
        checks++; if (acc !== 16'hFFFE) $display("FAIL sub got=%04h exp=FFFE", acc); else passed++;
`ifdef BIP_FLAGS_EN
        checks++; if ({zero, neg} !== 2'b01) $display("FAIL flags_neg got=%0b%0b exp=01", zero, neg); else passed++;
`endif
    endtask

    task automatic test_sel_reserved();
        settle(); rc0 = retireCount;
        issue(11'd1, 1, 2'b11, 1, 1, 0, 0, 0);
        checks++; if (acc !== 16'hFFFE) $display("FAIL selA11_acc got=%04h exp=FFFE", acc); else passed++;
        checks++; if (retire !== 1'b1) $display("FAIL selA11_retire got=%0b exp=1", retire); else passed++;
    endtask

    task automatic test_halt();
        ldi(11'd9);
        settle(); rc0 = retireCount;
        @(negedge clk);
        WrPC = 1'b0; instr_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (halted !== 1'b1) $display("FAIL halt_flag got=%0b exp=1", halted); else passed++;
        checks++; if (instr_ready !== 1'b0) $display("FAIL halt_ready got=%0b exp=0", instr_ready); else passed++;
        checks++; if (retire !== 1'b1) $display("FAIL halt_retire got=%0b exp=1", retire); else passed++;
        // keep offering an LDI while halted
        WrPC = 1'b1; SelA = 2'b01; WrAcc = 1'b1; RdRam = 1'b0; WrRam = 1'b0; operand = 11'd1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (acc !== 16'h0009) $display("FAIL halt_acc got=%04h exp=0009", acc); else passed++;
        checks++; if (retireCount - rc0 !== 1) $display("FAIL halt_retire_count got=%0d exp=1", retireCount - rc0); else passed++;
        checks++; if (halted !== 1'b1) $display("FAIL halt_sticky got=%0b exp=1", halted); else passed++;
        instr_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (acc !== 16'h0000) $display("FAIL halt_rst_acc got=%04h exp=0000", acc); else passed++;
        checks++; if (halted !== 1'b0) $display("FAIL halt_rst_halted got=%0b exp=0", halted); else passed++;
        @(negedge clk); rst = 1'b0;
        $display("halt sequence done acc=%04h halted=%0b", acc, halted);
    endtask

    task automatic test_rst_in_wait();
        ldi(11'd4);
        issue(11'd3, 1, 2'b10, 0, 1, 0, 0, 1);  // ADD 3
        rc0 = retireCount;
        checks++; if (instr_ready !== 1'b0) $display("FAIL wait_ready got=%0b exp=0", instr_ready); else passed++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (acc !== 16'h0000) $display("FAIL rstwait_acc got=%04h exp=0000", acc); else passed++;
        checks++; if (retire !== 1'b0) $display("FAIL rstwait_retire got=%0b exp=0", retire); else passed++;
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (instr_ready !== 1'b1) $display("FAIL rstwait_ready got=%0b exp=1", instr_ready); else passed++;
        ldi(11'd2);
        checks++; if (acc !== 16'h0002) $display("FAIL rstwait_run got=%04h exp=0002", acc); else passed++;
        checks++; if (retireCount - rc0 !== 0) $display("FAIL rstwait_retire_count got=%0d exp=0", retireCount - rc0); else passed++;
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_store_load();
        test_back_to_back();
        test_wrap();
        test_sub();
        test_sel_reserved();
        test_halt();
        test_rst_in_wait();
        settle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
